// File: rtl/bit_counter_param_if.sv
// Request/response bundle for bit_counter_param: requester drives start/mode/data_in, counter returns status and count.
// Optional abort line exists only when BITCOUNT_ABORT_EN is defined.
interface bit_counter_param_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  // start is level-held by the requester until done is seen; drop it for at least one edge between operations.
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
`ifdef BITCOUNT_ABORT_EN
  logic             abort;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [CW-1:0]    result;

`ifdef BITCOUNT_ABORT_EN
  modport master (output start, mode, data_in, abort, input ready, busy, done, result);
  modport slave  (input start, mode, data_in, abort, output ready, busy, done, result);
`else
  modport master (output start, mode, data_in, input ready, busy, done, result);
  modport slave  (input start, mode, data_in, output ready, busy, done, result);
`endif
endinterface

// File: rtl/bit_counter_param.sv
// Parametrised ones/zeros counter: captures an operand, consumes STEP bits per cycle, exits early once the rest is zero.
// Optional BITCOUNT_ABORT_EN adds an abort input honoured only while counting.
module bit_counter_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  bit_counter_param_if.slave   bus,
  output logic [1:0]           state_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    result_q, result_d;
  logic [CW-1:0]    slice_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      result_q <= result_d;
    end
  end

  // Popcount of the low STEP bits about to be shifted out.
  always_comb begin
    slice_pc = '0;
    for (int i = 0; i < STEP; i++) begin
      slice_pc = slice_pc + CW'(a_q[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.mode ? ~bus.data_in : bus.data_in;
          result_d = '0;
          state_d  = S_COUNT;
        end
      end
      S_COUNT: begin
`ifdef BITCOUNT_ABORT_EN
        if (bus.abort) begin
          a_d      = '0;
          result_d = '0;
          state_d  = S_IDLE;
        end else
`endif
        if (a_q == '0) begin
          state_d = S_DONE;
        end else begin
          result_d = result_q + slice_pc;
          a_d      = a_q >> STEP;
        end
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.busy   = (state_q == S_COUNT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_bit_counter_param.sv
// Bench for bit_counter_param: an 8-bit/STEP=1 and a 16-bit/STEP=4 instance, table vectors, corner sequences, random ops.
module tb_bit_counter_param;
  logic       clk;
  logic       reset;
  logic [1:0] st8, st16;
  int         total;
  int         bad;

  bit_counter_param_if #(.WIDTH(8))  if8 ();
  bit_counter_param_if #(.WIDTH(16)) if16 ();

  bit_counter_param #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .reset(reset), .bus(if8.slave), .state_o(st8)
  );
  bit_counter_param #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk(clk), .reset(reset), .bus(if16.slave), .state_o(st16)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        md;
    logic [15:0] d;
    int          hold;
    int          exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic md, input logic [15:0] d);
    if (sel == 0) begin
      if8.start = st; if8.mode = md; if8.data_in = d[7:0];
    end else begin
      if16.start = st; if16.mode = md; if16.data_in = d;
    end
  endtask

  function automatic int rd_res(input int sel);
    return (sel == 0) ? int'(if8.result) : int'(if16.result);
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel == 0) ? if8.done : if16.done;
  endfunction
  function automatic logic rd_busy(input int sel);
    return (sel == 0) ? if8.busy : if16.busy;
  endfunction
  function automatic logic rd_ready(input int sel);
    return (sel == 0) ? if8.ready : if16.ready;
  endfunction

  // Reference model: count of counted bits, and edges from E0 until done is visible.
  function automatic int model_res(input int sel, input logic md, input logic [15:0] d);
    logic [15:0] a;
    a = md ? ~d : d;
    if (sel == 0) a = a & 16'h00FF;
    return $countones(a);
  endfunction
  function automatic int model_lat(input int sel, input logic md, input logic [15:0] d);
    logic [15:0] a;
    int p, step;
    a = md ? ~d : d;
    if (sel == 0) a = a & 16'h00FF;
    step = (sel == 0) ? 1 : 4;
    if (a == 16'h0) return 1;
    p = 0;
    for (int i = 0; i < 16; i++) if (a[i]) p = i;
    return (p + step) / step + 1;
  endfunction

  // One full operation: start at E0, scramble inputs while counting, hold start, drop start.
  task automatic run_vec(input string name, input int sel, input logic md, input logic [15:0] d,
                         input int hold, input int exp_res, input int exp_lat);
    int n;
    drive(sel, 1'b1, md, d);
    @(posedge clk); #1;
    chk({name, " busy_after_e0"}, int'(rd_busy(sel)), 1);
    n = 0;
    while (!rd_done(sel) && n < 40) begin
      drive(sel, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
      @(posedge clk); #1;
      n++;
      if (!rd_done(sel) && !rd_busy(sel)) begin
        chk({name, " busy_while_counting"}, 0, 1);
        n = 40;
      end
    end
    chk({name, " latency"}, n, exp_lat);
    chk({name, " result"}, rd_res(sel), exp_res);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, " done_held"}, int'(rd_done(sel)), 1);
      chk({name, " result_held"}, rd_res(sel), exp_res);
    end
    drive(sel, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
    @(posedge clk); #1;
    chk({name, " ready_after_drop"}, int'(rd_ready(sel)), 1);
    chk({name, " result_in_idle"}, rd_res(sel), exp_res);
    @(posedge clk); #1;
    chk({name, " result_idle_hold"}, rd_res(sel), exp_res);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0);
`ifdef BITCOUNT_ABORT_EN
    if8.abort  = 1'b0;
    if16.abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset ready", int'(rd_ready(s)), 1);
      chk("reset busy", int'(rd_busy(s)), 0);
      chk("reset done", int'(rd_done(s)), 0);
      chk("reset result", rd_res(s), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    //            sel md    data      hold res lat
    vecs[0] = '{0, 1'b0, 16'h00B2, 3, 4,  9};
    vecs[1] = '{0, 1'b0, 16'h0000, 0, 0,  1};
    vecs[2] = '{0, 1'b1, 16'h0000, 1, 8,  9};
    vecs[3] = '{0, 1'b1, 16'h00F0, 2, 4,  5};
    vecs[4] = '{1, 1'b0, 16'hFFFF, 1, 16, 5};
    vecs[5] = '{1, 1'b0, 16'h0010, 0, 1,  3};
    vecs[6] = '{0, 1'b0, 16'h0001, 0, 1,  2};
    vecs[7] = '{1, 1'b1, 16'hFFFF, 0, 0,  1};
    vecs[8] = '{0, 1'b0, 16'h0080, 0, 1,  9};
    vecs[9] = '{1, 1'b0, 16'h8001, 1, 2,  5};
    for (int v = 0; v < 10; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].sel, vecs[v].md, vecs[v].d,
              vecs[v].hold, vecs[v].exp_res, vecs[v].exp_lat);
    end

    // Reset mid-COUNT, with start still asserted at the reset edge.
    drive(0, 1'b1, 1'b0, 16'h00FF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0);
    chk("midcount_reset ready", int'(if8.ready), 1);
    chk("midcount_reset busy", int'(if8.busy), 0);
    chk("midcount_reset done", int'(if8.done), 0);
    chk("midcount_reset result", int'(if8.result), 0);
    @(posedge clk); #1;
    run_vec("after_reset", 0, 1'b0, 16'h0001, 0, 1, 2);

    // Reset while holding in DONE clears the result.
    drive(0, 1'b1, 1'b0, 16'h000F);
    repeat (7) @(posedge clk);
    #1;
    chk("done_before_reset", int'(if8.done), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0);
    chk("done_reset ready", int'(if8.ready), 1);
    chk("done_reset result", int'(if8.result), 0);
    @(posedge clk); #1;

`ifdef BITCOUNT_ABORT_EN
    // Abort raised after E2, sampled at E3.
    drive(0, 1'b1, 1'b0, 16'h00FF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if8.abort = 1'b1;
    @(posedge clk); #1;
    if8.abort = 1'b0;
    chk("abort ready", int'(if8.ready), 1);
    chk("abort result", int'(if8.result), 0);
    chk("abort done", int'(if8.done), 0);
    drive(0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no_done", int'(if8.done), 0);
    end
    run_vec("after_abort", 0, 1'b0, 16'h0003, 0, 2, 3);
`endif

    // Random operations against the model.
    for (int r = 0; r < 40; r++) begin
      int          sel;
      logic        md;
      logic [15:0] d;
      sel = $urandom_range(0, 1);
      md  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & 16'h000F;
      run_vec($sformatf("rand%0d", r), sel, md, d, $urandom_range(0, 3),
              model_res(sel, md, d), model_lat(sel, md, d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
